// File: rtl/score_pkg.sv
// Shared types and constants for the score display path.
package score_pkg;

  localparam int SCORE_W = 16;
  localparam logic [SCORE_W-1:0] SCORE_MAX = 16'd9999;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    SHIFT,
    COMMIT
  } state_t;

  // Active-low segments, bit order {g,f,e,d,c,b,a}.
  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  function automatic logic [15:0] dd_adjust(
    input logic [15:0] b
  );
    logic [15:0] r;
    r = b;
    for (int i = 0; i < 4; i++) begin
      if (b[i*4 +: 4] >= 4'd5) begin
        r[i*4 +: 4] = b[i*4 +: 4] + 4'd3;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/score_display_seg7_decode.sv
// BCD digit to active-low 7-segment pattern.
// Codes 10-15 and the blank request both produce an unlit digit.
module seg7_decode
  import score_pkg::*;
(
  input  logic [3:0] bcd,
  input  logic       blank,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    if (!blank) begin
      unique case (bcd)
        4'd0:    seg = SEG_0;
        4'd1:    seg = SEG_1;
        4'd2:    seg = SEG_2;
        4'd3:    seg = SEG_3;
        4'd4:    seg = SEG_4;
        4'd5:    seg = SEG_5;
        4'd6:    seg = SEG_6;
        4'd7:    seg = SEG_7;
        4'd8:    seg = SEG_8;
        4'd9:    seg = SEG_9;
        default: seg = SEG_BLANK;
      endcase
    end
  end

endmodule

// File: rtl/score_display.sv
// Score bus to 4-digit multiplexed 7-seg display via double-dabble.
// SCORE_LZ_BLANK_EN: blank leading zero digits (units always shown).
module score_display #(
  parameter int                REFRESH_DIV = 50000,
  parameter logic [15:0]       SCORE_MAX   = score_pkg::SCORE_MAX
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] score,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        dp,
  output logic        busy,
  output logic        ovf
);

  localparam int RW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [RW-1:0] RLAST = RW'(REFRESH_DIV - 1);

  score_pkg::state_t state_q, state_d;

  logic [15:0]   bin_q, bin_d;
  logic [15:0]   bcd_q, bcd_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [15:0]   last_q, last_d;
  logic          ovfp_q, ovfp_d;
  logic          busy_q, busy_d;
  logic          ovf_q, ovf_d;
  logic [15:0]   dig_q, dig_d;
  logic [RW-1:0] rcnt_q, rcnt_d;
  logic [1:0]    idx_q, idx_d;
  logic [3:0]    an_q, an_d;
  logic [6:0]    seg_q, seg_d;

  logic [15:0] bcd_sh;
  logic [15:0] bin_sh;
  logic        over;
  logic [3:0]  cur_dig;
  logic        blank;

  assign over = score > SCORE_MAX;
  assign {bcd_sh, bin_sh} = {score_pkg::dd_adjust(bcd_q), bin_q} << 1;

  always_comb begin
    state_d = state_q;
    bin_d   = bin_q;
    bcd_d   = bcd_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
    ovfp_d  = ovfp_q;
    busy_d  = busy_q;
    ovf_d   = ovf_q;
    dig_d   = dig_q;
    unique case (state_q)
      score_pkg::IDLE: begin
        if (score != last_q) begin
          state_d = score_pkg::LOAD;
          busy_d  = 1'b1;
        end
      end
      score_pkg::LOAD: begin
        bin_d   = over ? SCORE_MAX : score;
        last_d  = score;
        ovfp_d  = over;
        bcd_d   = '0;
        cnt_d   = '0;
        state_d = score_pkg::SHIFT;
      end
      score_pkg::SHIFT: begin
        bcd_d = bcd_sh;
        bin_d = bin_sh;
        cnt_d = cnt_q + 4'd1;
        // Publish on the final shift so old digits hold until then.
        if (cnt_q == 4'd15) begin
          state_d = score_pkg::COMMIT;
          dig_d   = bcd_sh;
          ovf_d   = ovfp_q;
          busy_d  = 1'b0;
        end
      end
      score_pkg::COMMIT: begin
        if (score != last_q) begin
          state_d = score_pkg::LOAD;
          busy_d  = 1'b1;
        end else begin
          state_d = score_pkg::IDLE;
        end
      end
      default: state_d = score_pkg::IDLE;
    endcase
  end

  always_comb begin
    rcnt_d = rcnt_q + RW'(1);
    idx_d  = idx_q;
    if (rcnt_q == RLAST) begin
      rcnt_d = '0;
      idx_d  = idx_q + 2'd1;
    end
    an_d    = ~(4'b0001 << idx_d);
    cur_dig = dig_d[{idx_d, 2'b00} +: 4];
  end

`ifdef SCORE_LZ_BLANK_EN
  logic [3:0] lz;
  always_comb begin
    lz[3] = (dig_d[15:12] == 4'd0);
    lz[2] = lz[3] && (dig_d[11:8] == 4'd0);
    lz[1] = lz[2] && (dig_d[7:4] == 4'd0);
    lz[0] = 1'b0;
    blank = lz[idx_d];
  end
`else
  assign blank = 1'b0;
`endif

  seg7_decode u_dec (
    .bcd   (cur_dig),
    .blank (blank),
    .seg   (seg_d)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= score_pkg::IDLE;
      bin_q   <= '0;
      bcd_q   <= '0;
      cnt_q   <= '0;
      last_q  <= '0;
      ovfp_q  <= 1'b0;
      busy_q  <= 1'b0;
      ovf_q   <= 1'b0;
      dig_q   <= '0;
      rcnt_q  <= '0;
      idx_q   <= '0;
      an_q    <= 4'hF;
      seg_q   <= score_pkg::SEG_BLANK;
    end else begin
      state_q <= state_d;
      bin_q   <= bin_d;
      bcd_q   <= bcd_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
      ovfp_q  <= ovfp_d;
      busy_q  <= busy_d;
      ovf_q   <= ovf_d;
      dig_q   <= dig_d;
      rcnt_q  <= rcnt_d;
      idx_q   <= idx_d;
      an_q    <= an_d;
      seg_q   <= seg_d;
    end
  end

  assign an   = an_q;
  assign seg  = seg_q;
  assign dp   = 1'b1;
  assign busy = busy_q;
  assign ovf  = ovf_q;

endmodule
